// File: rtl/shift_unit_seq.sv
// Iterative shift/rotate unit: one barrel stage per cycle, valid/ready on both sides.
// Modes SLL/SRL/SRA/ROL/ROR; reports carry-out, zero and illegal-mode flags.
module shift_unit_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic [2:0]         Mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Y,
    output logic               Carry,
    output logic               Zero,
    output logic               Err
);

    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [K_W-1:0]     r_k;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_a0;
    logic [SHAMT_W-1:0] r_shamt;
    logic [2:0]         r_mode;
    logic [WIDTH-1:0]   r_y;
    logic               r_carry;
    logic               r_zero;
    logic               r_err;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [SHAMT_W-1:0] w_amt;
    logic [SHAMT_W-1:0] w_ramt;
    logic [SHAMT_W-1:0] w_sll_idx;
    logic [SHAMT_W-1:0] w_srl_idx;
    logic [WIDTH-1:0]   w_stage;
    logic [WIDTH-1:0]   w_work_nxt;
    logic               w_carry;
    logic               w_illegal;
    logic               w_accept;

    assign w_accept  = in_valid && r_in_ready;
    assign w_illegal = (r_mode > 3'd4);

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_SHIFT;
                else          w_state_nxt = S_IDLE;
            end
            S_SHIFT: begin
                if (r_k == K_LAST) w_state_nxt = S_DONE;
                else               w_state_nxt = S_SHIFT;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One barrel stage of 2^k; WIDTH is a power of two, so WIDTH-x wraps to 0-x.
    always_comb begin
        w_amt   = SHAMT_W'(1) << r_k;
        w_ramt  = {SHAMT_W{1'b0}} - w_amt;
        w_stage = r_work;
        case (r_mode)
            3'b000:  w_stage = r_work << w_amt;
            3'b001:  w_stage = r_work >> w_amt;
            3'b010:  w_stage = WIDTH'($signed(r_work) >>> w_amt);
            3'b011:  w_stage = (r_work << w_amt) | (r_work >> w_ramt);
            3'b100:  w_stage = (r_work >> w_amt) | (r_work << w_ramt);
            default: w_stage = r_work;
        endcase
        if (r_shamt[r_k]) w_work_nxt = w_stage;
        else              w_work_nxt = r_work;
    end

    // Carry-out of the whole operation, valid when the final stage is applied.
    always_comb begin
        w_sll_idx = {SHAMT_W{1'b0}} - r_shamt;
        w_srl_idx = r_shamt - SHAMT_W'(1);
        w_carry   = 1'b0;
        if (r_shamt == {SHAMT_W{1'b0}}) begin
            w_carry = 1'b0;
        end else begin
            case (r_mode)
                3'b000:  w_carry = r_a0[w_sll_idx];
                3'b001:  w_carry = r_a0[w_srl_idx];
                3'b010:  w_carry = r_a0[w_srl_idx];
                3'b011:  w_carry = w_work_nxt[0];
                3'b100:  w_carry = w_work_nxt[WIDTH-1];
                default: w_carry = 1'b0;
            endcase
        end
    end

    // State, working register and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= {K_W{1'b0}};
            r_work      <= {WIDTH{1'b0}};
            r_a0        <= {WIDTH{1'b0}};
            r_shamt     <= {SHAMT_W{1'b0}};
            r_mode      <= 3'b000;
            r_y         <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a0    <= A;
                        r_work  <= A;
                        r_shamt <= Shamt;
                        r_mode  <= Mode;
                        r_k     <= {K_W{1'b0}};
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_nxt;
                    r_k    <= r_k + K_W'(1);
                    if (r_k == K_LAST) begin
                        r_y     <= w_work_nxt;
                        r_carry <= w_carry;
                        r_zero  <= (w_work_nxt == {WIDTH{1'b0}});
                        r_err   <= w_illegal;
                    end
                end
                S_DONE: begin
                    r_work <= r_work;
                end
                default: begin
                    r_work <= r_work;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Y         = r_y;
    assign Carry     = r_carry;
    assign Zero      = r_zero;
    assign Err       = r_err;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=8) with hand-computed expected results.
module tb_shift_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [2:0] Shamt;
    logic [2:0] Mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y;
    logic       Carry;
    logic       Zero;
    logic       Err;

    int checks = 0;
    int errors = 0;

    shift_unit_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .Shamt     (Shamt),
        .Mode      (Mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Carry     (Carry),
        .Zero      (Zero),
        .Err       (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full request with out_ready held high; checks latency, result and return to idle.
    task automatic run(input string tag, input logic [7:0] a, input logic [2:0] s,
                       input logic [2:0] m, input logic [7:0] ey, input logic ec,
                       input logic ez, input logic ee);
        @(negedge clk);
        in_valid  = 1'b1;
        A         = a;
        Shamt     = s;
        Mode      = m;
        out_ready = 1'b1;
        #1;
        chk1($sformatf("%s.in_ready_before", tag), in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("%s.out_valid_c%0d", tag, i), out_valid, (i == 3));
        end
        chk8($sformatf("%s.y", tag), Y, ey);
        chk1($sformatf("%s.carry", tag), Carry, ec);
        chk1($sformatf("%s.zero", tag), Zero, ez);
        chk1($sformatf("%s.err", tag), Err, ee);
        chk1($sformatf("%s.in_ready_busy", tag), in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1($sformatf("%s.out_valid_after", tag), out_valid, 1'b0);
        chk1($sformatf("%s.in_ready_after", tag), in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = 8'h00;
        Shamt     = 3'd0;
        Mode      = 3'b000;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst.in_ready", in_ready, 1'b0);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk8("rst.y", Y, 8'h00);
        chk1("rst.carry", Carry, 1'b0);
        chk1("rst.zero", Zero, 1'b0);
        chk1("rst.err", Err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("rel.in_ready", in_ready, 1'b1);
        chk1("rel.out_valid", out_valid, 1'b0);

        // Directed vectors
        run("sra96_3", 8'h96, 3'd3, 3'b010, 8'hF2, 1'b1, 1'b0, 1'b0);
        run("sll81_1", 8'h81, 3'd1, 3'b000, 8'h02, 1'b1, 1'b0, 1'b0);
        run("srl0f_4", 8'h0F, 3'd4, 3'b001, 8'h00, 1'b1, 1'b1, 1'b0);
        run("srl80_7", 8'h80, 3'd7, 3'b001, 8'h01, 1'b0, 1'b0, 1'b0);
        run("ror01_1", 8'h01, 3'd1, 3'b100, 8'h80, 1'b1, 1'b0, 1'b0);
        run("rola5_4", 8'hA5, 3'd4, 3'b011, 8'h5A, 1'b0, 1'b0, 1'b0);
        run("rol77_0", 8'h77, 3'd0, 3'b011, 8'h77, 1'b0, 1'b0, 1'b0);
        run("sra77_0", 8'h77, 3'd0, 3'b010, 8'h77, 1'b0, 1'b0, 1'b0);
        run("ill3c_2", 8'h3C, 3'd2, 3'b110, 8'h3C, 1'b0, 1'b0, 1'b1);
        run("sll01_7", 8'h01, 3'd7, 3'b000, 8'h80, 1'b0, 1'b0, 1'b0);
        run("srae1_6", 8'hE1, 3'd6, 3'b010, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Backpressure: second request held on in_valid while the first is stalled
        @(negedge clk);
        in_valid  = 1'b1;
        A         = 8'h0F;
        Shamt     = 3'd4;
        Mode      = 3'b001;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        A     = 8'h96;
        Shamt = 3'd3;
        Mode  = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        chk1("bp.out_valid_first", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("bp.hold%0d.out_valid", i), out_valid, 1'b1);
            chk8($sformatf("bp.hold%0d.y", i), Y, 8'h00);
            chk1($sformatf("bp.hold%0d.carry", i), Carry, 1'b1);
            chk1($sformatf("bp.hold%0d.zero", i), Zero, 1'b1);
            chk1($sformatf("bp.hold%0d.err", i), Err, 1'b0);
            chk1($sformatf("bp.hold%0d.in_ready", i), in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("bp.release.out_valid", out_valid, 1'b0);
        chk1("bp.release.in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk1("bp.second_accepted", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk1("bp.second.out_valid", out_valid, 1'b1);
        chk8("bp.second.y", Y, 8'hF2);
        chk1("bp.second.carry", Carry, 1'b1);
        chk1("bp.second.zero", Zero, 1'b0);
        @(posedge clk);
        #1;
        chk1("bp.second.done", out_valid, 1'b0);

        // Asynchronous reset during SHIFT stage 1
        @(negedge clk);
        in_valid = 1'b1;
        A        = 8'h0F;
        Shamt    = 3'd1;
        Mode     = 3'b000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("arst.y", Y, 8'h00);
        chk1("arst.carry", Carry, 1'b0);
        chk1("arst.out_valid", out_valid, 1'b0);
        chk1("arst.in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("arst.rel.in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("arst.nostale%0d", i), out_valid, 1'b0);
        end
        run("sra80_7", 8'h80, 3'd7, 3'b010, 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
